// File: rtl/reg_index_seq.sv
// reg_index_seq: index sequencer in front of the register-file read port.
// It accepts one vector command, then issues one read request per
// non-stalled cycle. Each operand index starts at its base and steps by its
// stride, wrapping modulo NUM_REGS. It flags the final element and pulses
// done one cycle after the final element.
module reg_index_seq #(
    parameter int NUM_REGS = 64,
    parameter int IDX_W    = 6,
    parameter int LEN_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             I_Cmd_Valid,
    output logic             O_Cmd_Ready,
    input  logic [LEN_W-1:0] I_Length,
    input  logic             I_Src1_V,
    input  logic [IDX_W-1:0] I_Src1_Base,
    input  logic [IDX_W-1:0] I_Src1_Stride,
    input  logic             I_Src2_V,
    input  logic [IDX_W-1:0] I_Src2_Base,
    input  logic [IDX_W-1:0] I_Src2_Stride,
    input  logic             I_Dst_V,
    input  logic [IDX_W-1:0] I_Dst_Base,
    input  logic [IDX_W-1:0] I_Dst_Stride,
    input  logic             I_Stall,
    output logic             O_Req,
    output logic             O_Src1_V,
    output logic [IDX_W-1:0] O_Index_Src1,
    output logic             O_Src2_V,
    output logic [IDX_W-1:0] O_Index_Src2,
    output logic             O_Dst_V,
    output logic [IDX_W-1:0] O_Index_Dst,
    output logic             O_Last,
    output logic             O_Done
);

    // The mask wraps the index modulo the register-file depth. It is a
    // no-op when NUM_REGS == 2**IDX_W, but keeps the two parameters tied.
    localparam int unsigned IDX_MASK_I = NUM_REGS - 1;
    localparam logic [IDX_W-1:0] IDX_MASK = IDX_MASK_I[IDX_W-1:0];

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0] src1_idx, src1_stride;
    logic [IDX_W-1:0] src2_idx, src2_stride;
    logic [IDX_W-1:0] dst_idx, dst_stride;
    logic             src1_v, src2_v, dst_v;
    logic [LEN_W-1:0] count;
    logic             done_q;

    logic accept;
    logic advance;
    logic last_elem;

    assign accept    = (state == IDLE) && I_Cmd_Valid;
    assign advance   = (state == RUN) && !I_Stall;
    assign last_elem = advance && (count == LEN_W'(1));

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so that every flop samples
    // the pre-edge values. Blocking here would create order-dependent races.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic. A zero-length command never leaves IDLE.
    // NOTE: state_next gets a default before the case so that no path leaves
    // it unassigned. Without that default, synthesis would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept && (I_Length != '0)) state_next = RUN;
            RUN:  if (last_elem)                  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command latch and per-element stepping. Stalled cycles hold everything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            src1_idx    <= '0;
            src1_stride <= '0;
            src1_v      <= 1'b0;
            src2_idx    <= '0;
            src2_stride <= '0;
            src2_v      <= 1'b0;
            dst_idx     <= '0;
            dst_stride  <= '0;
            dst_v       <= 1'b0;
            count       <= '0;
        end else if (accept) begin
            src1_idx    <= I_Src1_Base;
            src1_stride <= I_Src1_Stride;
            src1_v      <= I_Src1_V;
            src2_idx    <= I_Src2_Base;
            src2_stride <= I_Src2_Stride;
            src2_v      <= I_Src2_V;
            dst_idx     <= I_Dst_Base;
            dst_stride  <= I_Dst_Stride;
            dst_v       <= I_Dst_V;
            count       <= I_Length;
        end else if (advance) begin
            // Operands with V=0 still advance so all three stay in lockstep.
            src1_idx <= (src1_idx + src1_stride) & IDX_MASK;
            src2_idx <= (src2_idx + src2_stride) & IDX_MASK;
            dst_idx  <= (dst_idx + dst_stride) & IDX_MASK;
            count    <= count - LEN_W'(1);
        end
    end

    // Done pulse: one cycle after the final element, or one cycle after a
    // zero-length command is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) done_q <= 1'b0;
        else       done_q <= last_elem || (accept && (I_Length == '0));
    end

    // Output decode. The request and its qualifiers follow the stall input
    // combinationally, so a stalled cycle shows no request at all.
    always_comb begin
        O_Cmd_Ready  = (state == IDLE);
        O_Req        = advance;
        O_Src1_V     = advance && src1_v;
        O_Src2_V     = advance && src2_v;
        O_Dst_V      = advance && dst_v;
        O_Last       = last_elem;
        O_Done       = done_q;
        O_Index_Src1 = src1_idx;
        O_Index_Src2 = src2_idx;
        O_Index_Dst  = dst_idx;
    end

endmodule
